demux1x2_buffered: RTL and testbench

- Distributes one 4-bit nibble stream to one of two destinations, selected by SEL. It is the write/distribution counterpart of the game's 2:1 source-select mux.
- Each destination has a one-entry output register with a valid/ready handshake and a transfer counter.
- Sits between the play/sequence generator and the two consumers: memory-write path (channel 0) and display/compare path (channel 1).

---
 rtl/demux1x2_buffered.sv | 120 ++++++++++++
 tb/tb_demux1x2_buffered.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/demux1x2_buffered.sv
// demux1x2_buffered -- routes one nibble stream to one of two buffered outputs.
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   flush                  clears both output buffers (counters kept)
//   D, SEL, in_valid       input nibble, destination select, input valid
//   in_ready               input accepted this cycle when in_valid is also high
//   OUTn, outn_valid       registered channel data / channel holds data
//   outn_ready             channel consumer takes data
//   cntn                   completed transfers on channel n, wrapping
//
// Channel 0 feeds the memory-write path, channel 1 the display/compare path.

// One output channel: single-entry register, valid flag and drain counter.
module demux1x2_buffered_chan #(
    parameter int                 WIDTH      = 4,
    parameter int                 CNT_WIDTH  = 4,
    parameter logic [WIDTH-1:0]   IDLE_VALUE = {WIDTH{1'b1}}
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 accept,
    input  logic [WIDTH-1:0]     din,
    input  logic                 ready,
    output logic [WIDTH-1:0]     dout,
    output logic                 valid,
    output logic [CNT_WIDTH-1:0] cnt
);
    logic drain;
    assign drain = valid & ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            dout  <= IDLE_VALUE;
            cnt   <= '0;
        end else if (flush) begin
            // A drain coinciding with flush is discarded, so no count.
            valid <= 1'b0;
            dout  <= IDLE_VALUE;
        end else begin
            if (drain)
                cnt <= cnt + 1'b1;
            if (accept) begin
                dout  <= din;
                valid <= 1'b1;
            end else if (drain) begin
                valid <= 1'b0;
                dout  <= IDLE_VALUE;
            end
        end
    end
endmodule

module demux1x2_buffered #(
    parameter int                 WIDTH      = 4,
    parameter int                 CNT_WIDTH  = 4,
    parameter logic [WIDTH-1:0]   IDLE_VALUE = {WIDTH{1'b1}}
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     D,
    input  logic                 SEL,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     OUT0,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     OUT1,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
);
    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0]                ch_valid;
    logic [NUM_CH-1:0]                ch_ready;
    logic [NUM_CH-1:0]                ch_accept;
    logic [NUM_CH-1:0][WIDTH-1:0]     ch_data;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] ch_cnt;

    assign ch_ready = {out1_ready, out0_ready};

    // Only the selected channel can stall input; a full idle-side channel
    // never blocks the other destination.
    assign in_ready = ~reset & ~flush & (~ch_valid[SEL] | ch_ready[SEL]);

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            assign ch_accept[i] = in_valid & in_ready & (SEL == 1'(i));

            demux1x2_buffered_chan #(
                .WIDTH      (WIDTH),
                .CNT_WIDTH  (CNT_WIDTH),
                .IDLE_VALUE (IDLE_VALUE)
            ) u_chan (
                .clock  (clock),
                .reset  (reset),
                .flush  (flush),
                .accept (ch_accept[i]),
                .din    (D),
                .ready  (ch_ready[i]),
                .dout   (ch_data[i]),
                .valid  (ch_valid[i]),
                .cnt    (ch_cnt[i])
            );
        end
    endgenerate

    assign OUT0       = ch_data[0];
    assign OUT1       = ch_data[1];
    assign out0_valid = ch_valid[0];
    assign out1_valid = ch_valid[1];
    assign cnt0       = ch_cnt[0];
    assign cnt1       = ch_cnt[1];
endmodule

// File: tb/tb_demux1x2_buffered.sv
// Directed bench for demux1x2_buffered with hand-computed expectations.
module tb_demux1x2_buffered;
    logic       clock = 1'b0;
    logic       reset, flush, SEL, in_valid, in_ready;
    logic [3:0] D, OUT0, OUT1, cnt0, cnt1;
    logic       out0_valid, out0_ready, out1_valid, out1_ready;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    demux1x2_buffered dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .D          (D),
        .SEL        (SEL),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .OUT0       (OUT0),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .OUT1       (OUT1),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; D = 4'h0; SEL = 1'b0; in_valid = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_out0", OUT0, 4'hF);
        chk("rst_out1", OUT1, 4'hF);
        chk("rst_v0", out0_valid, 0);
        chk("rst_v1", out1_valid, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("idle_in_ready", in_ready, 1);

        // Fill channel 0, then it blocks SEL=0 but not SEL=1.
        D = 4'h5; SEL = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("acc_out0", OUT0, 4'h5);
        chk("acc_v0", out0_valid, 1);
        chk("acc_out1", OUT1, 4'hF);
        chk("acc_v1", out1_valid, 0);
        D = 4'hA; SEL = 1'b0; in_valid = 1'b1;
        #1;
        chk("full_in_ready", in_ready, 0);
        tick();
        chk("hold_out0", OUT0, 4'h5);
        chk("hold_v1", out1_valid, 0);
        SEL = 1'b1;
        #1;
        chk("other_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("acc_out1_a", OUT1, 4'hA);
        chk("acc_v1_a", out1_valid, 1);
        chk("still_out0", OUT0, 4'h5);

        // Drain both.
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        out0_ready = 1'b0; out1_ready = 1'b0;
        chk("drain_v0", out0_valid, 0);
        chk("drain_v1", out1_valid, 0);
        chk("drain_out0", OUT0, 4'hF);
        chk("drain_out1", OUT1, 4'hF);
        chk("drain_cnt0", cnt0, 1);
        chk("drain_cnt1", cnt1, 1);

        // Simultaneous accept and drain on channel 0.
        D = 4'h3; SEL = 1'b0; in_valid = 1'b1;
        tick();
        D = 4'h7; out0_ready = 1'b1;
        #1;
        chk("pass_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; out0_ready = 1'b0;
        chk("pass_out0", OUT0, 4'h7);
        chk("pass_v0", out0_valid, 1);
        chk("pass_cnt0", cnt0, 2);

        // Accept on channel 1 while channel 0 drains.
        D = 4'h4; SEL = 1'b1; in_valid = 1'b1; out0_ready = 1'b1;
        tick();
        in_valid = 1'b0; out0_ready = 1'b0;
        chk("indep_out1", OUT1, 4'h4);
        chk("indep_v1", out1_valid, 1);
        chk("indep_v0", out0_valid, 0);
        chk("indep_out0", OUT0, 4'hF);
        chk("indep_cnt0", cnt0, 3);
        chk("indep_cnt1", cnt1, 1);

        // Fresh reset, then stream 17 nibbles into channel 1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out1_ready = 1'b1; SEL = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            D = 4'(k + 2);
            #1;
            chk($sformatf("strm_rdy%0d", k), in_ready, 1);
            tick();
            chk($sformatf("strm_out%0d", k), OUT1, 32'((k + 2) % 16));
            chk($sformatf("strm_cnt%0d", k), cnt1, 32'(k % 16));
        end
        in_valid = 1'b0;
        tick();
        out1_ready = 1'b0;
        chk("strm_end_cnt", cnt1, 1);
        chk("strm_end_v1", out1_valid, 0);
        chk("strm_end_out1", OUT1, 4'hF);

        // Flush with both full and a drain pending on channel 0.
        D = 4'h9; SEL = 1'b0; in_valid = 1'b1;
        tick();
        D = 4'h6; SEL = 1'b1;
        tick();
        chk("pre_flush_v0", out0_valid, 1);
        chk("pre_flush_v1", out1_valid, 1);
        flush = 1'b1; out0_ready = 1'b1; D = 4'h2; SEL = 1'b0;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out0_ready = 1'b0;
        chk("flush_v0", out0_valid, 0);
        chk("flush_v1", out1_valid, 0);
        chk("flush_out0", OUT0, 4'hF);
        chk("flush_out1", OUT1, 4'hF);
        chk("flush_cnt0", cnt0, 0);
        chk("flush_cnt1", cnt1, 1);

        // Reset mid-stream with channel 1 full and input offered.
        D = 4'hC; SEL = 1'b1; in_valid = 1'b1;
        tick();
        chk("pre_rst_out1", OUT1, 4'hC);
        reset = 1'b1; D = 4'h4; SEL = 1'b0; out1_ready = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        tick();
        reset = 1'b0; in_valid = 1'b0; out1_ready = 1'b0;
        #1;
        chk("mrst_v0", out0_valid, 0);
        chk("mrst_v1", out1_valid, 0);
        chk("mrst_out0", OUT0, 4'hF);
        chk("mrst_out1", OUT1, 4'hF);
        chk("mrst_cnt0", cnt0, 0);
        chk("mrst_cnt1", cnt1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
